// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single multi-cycle main memory between I-cache
// block fills, D-cache block fills and D-side write-throughs. A fill issues
// WORDS consecutive reads, steers each returned word into the cache that
// asked for it, and finishes with a one-cycle done pulse. The stall outputs
// gate the pipeline register write enables while a request is outstanding.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              dwrite_req,
    input  logic [ADDR_W-1:0] dwrite_addr,
    input  logic [ADDR_W-1:0] dwrite_data,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              dwrite_ack,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic [CNT_W-1:0]  fill_word,
    output logic              fill_done_i,
    output logic              fill_done_d,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Block base clears the byte offset within a block of WORDS 16-bit words.
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS - 1);
    // Issue counter is one bit wider so "all WORDS issued" is representable.
    localparam logic [CNT_W:0]    ISSUE_END  = (CNT_W + 1)'(WORDS);
    localparam logic [CNT_W:0]    ISSUE_ONE  = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  RECV_ONE   = CNT_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W:0]      issue_cnt_r;
    logic [CNT_W:0]      issue_cnt_s;
    logic [CNT_W-1:0]    recv_cnt_r;
    logic [CNT_W-1:0]    recv_cnt_s;
    logic                target_d_r;   // 1 = D-cache fill, 0 = I-cache fill
    logic                target_d_s;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   base_s;
    logic [ADDR_W-1:0]   word_offset_s;

    // Byte offset of the word currently being issued (word index * 2).
    assign word_offset_s = {{(ADDR_W - CNT_W - 1){1'b0}}, issue_cnt_r[CNT_W-1:0], 1'b0};

    // State and bookkeeping registers; reset abandons any fill in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            issue_cnt_r <= '0;
            recv_cnt_r  <= '0;
            target_d_r  <= 1'b0;
            base_r      <= '0;
        end else begin
            state_r     <= state_s;
            issue_cnt_r <= issue_cnt_s;
            recv_cnt_r  <= recv_cnt_s;
            target_d_r  <= target_d_s;
            base_r      <= base_s;
        end
    end

    // Next-state selection, fixed-priority arbitration and memory/fill outputs.
    always_comb begin
        state_s     = state_r;
        issue_cnt_s = issue_cnt_r;
        recv_cnt_s  = recv_cnt_r;
        target_d_s  = target_d_r;
        base_s      = base_r;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dwrite_ack  = 1'b0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_word   = '0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // D-miss beats write-through beats I-miss; a pending store
                // that also missed is therefore filled before it is written.
                if (dcache_miss) begin
                    base_s      = dcache_miss_addr & BLOCK_MASK;
                    target_d_s  = 1'b1;
                    issue_cnt_s = '0;
                    recv_cnt_s  = '0;
                    state_s     = ST_FILL;
                end else if (dwrite_req) begin
                    state_s = ST_WR;
                end else if (icache_miss) begin
                    base_s      = icache_miss_addr & BLOCK_MASK;
                    target_d_s  = 1'b0;
                    issue_cnt_s = '0;
                    recv_cnt_s  = '0;
                    state_s     = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WR: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dwrite_addr;
                mem_wdata  = dwrite_data;
                dwrite_ack = 1'b1;
                state_s    = ST_IDLE;
            end

            ST_FILL: begin
                // Issue side runs back-to-back, independent of returns.
                if (issue_cnt_r < ISSUE_END) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_r + word_offset_s;
                    issue_cnt_s = issue_cnt_r + ISSUE_ONE;
                end else begin
                    issue_cnt_s = issue_cnt_r;
                end
                // Receive side: words arrive in issue order.
                if (mem_data_valid) begin
                    fill_we_d  = target_d_r;
                    fill_we_i  = ~target_d_r;
                    fill_word  = recv_cnt_r;
                    recv_cnt_s = recv_cnt_r + RECV_ONE;
                    if (recv_cnt_r == LAST_WORD) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    recv_cnt_s = recv_cnt_r;
                end
            end

            ST_DONE: begin
                fill_done_d = target_d_r;
                fill_done_i = ~target_d_r;
                issue_cnt_s = '0;
                recv_cnt_s  = '0;
                state_s     = ST_IDLE;
            end

            default: begin
                issue_cnt_s = '0;
                recv_cnt_s  = '0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // Stalls release in the very cycle the blocking request is satisfied.
    assign stall_mem = (dcache_miss & ~fill_done_d) | (dwrite_req & ~dwrite_ack);
    assign stall_if  = (icache_miss & ~fill_done_i) | stall_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scenarios against a timeline model
// of the arbiter. Memory is modelled as a fixed 4-cycle read pipeline; a fill
// is described by its age (cycles since it started): reads at ages 0..7,
// words 0..7 returned at ages 4..11, done at age 12.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        dwrite_req;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic        mem_data_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        dwrite_ack;
    logic        fill_we_i;
    logic        fill_we_d;
    logic [2:0]  fill_word;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        stall_if;
    logic        stall_mem;

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .dwrite_req       (dwrite_req),
        .dwrite_addr      (dwrite_addr),
        .dwrite_data      (dwrite_data),
        .mem_data_valid   (mem_data_valid),
        .mem_en           (mem_en),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .dwrite_ack       (dwrite_ack),
        .fill_we_i        (fill_we_i),
        .fill_we_d        (fill_we_d),
        .fill_word        (fill_word),
        .fill_done_i      (fill_done_i),
        .fill_done_d      (fill_done_d),
        .stall_if         (stall_if),
        .stall_mem        (stall_mem)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: 0 = idle, 1 = write-through, 2 = fill.
    int          m_kind = 0;
    int          m_age  = 0;
    logic [15:0] m_base = 16'h0000;
    bit          m_tgt_d = 1'b0;
    logic [3:0]  rd_pipe = 4'b0000;
    bit          chk_en  = 1'b0;
    bit          chk_all = 1'b0;
    bit          last_done_i, last_done_d, last_wr;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance model and memory.
    task automatic cycle();
        bit          e_en, e_wr, e_ack, e_wei, e_wed, e_di, e_dd, e_smem, e_sif, rd_now;
        logic [15:0] e_addr, e_wdata;
        logic [2:0]  e_word;
        int          n_kind, n_age;
        @(negedge clk);
        e_en = 0; e_wr = 0; e_ack = 0; e_wei = 0; e_wed = 0; e_di = 0; e_dd = 0;
        e_addr = 16'h0000; e_wdata = 16'h0000; e_word = 3'd0;
        if (m_kind == 1) begin
            e_en = 1; e_wr = 1; e_ack = 1; e_addr = dwrite_addr; e_wdata = dwrite_data;
        end else if (m_kind == 2) begin
            if (m_age < 8) begin
                e_en = 1; e_addr = m_base + 16'(2 * m_age);
            end
            if (m_age >= 4 && m_age < 12) begin
                e_wed = m_tgt_d; e_wei = !m_tgt_d; e_word = 3'(m_age - 4);
            end
            if (m_age == 12) begin
                e_dd = m_tgt_d; e_di = !m_tgt_d;
            end
        end
        e_smem = (dcache_miss && !e_dd) || (dwrite_req && !e_ack);
        e_sif  = (icache_miss && !e_di) || e_smem;
        if (chk_en) begin
            check("mem_en", {15'd0, mem_en}, {15'd0, e_en});
            if (e_en || chk_all) begin
                check("mem_wr", {15'd0, mem_wr}, {15'd0, e_wr});
                check("mem_addr", mem_addr, e_addr);
            end
            if (e_wr || chk_all) check("mem_wdata", mem_wdata, e_wdata);
            check("dwrite_ack", {15'd0, dwrite_ack}, {15'd0, e_ack});
            check("fill_we_i", {15'd0, fill_we_i}, {15'd0, e_wei});
            check("fill_we_d", {15'd0, fill_we_d}, {15'd0, e_wed});
            if (e_wei || e_wed || chk_all) check("fill_word", {13'd0, fill_word}, {13'd0, e_word});
            check("fill_done_i", {15'd0, fill_done_i}, {15'd0, e_di});
            check("fill_done_d", {15'd0, fill_done_d}, {15'd0, e_dd});
            check("stall_mem", {15'd0, stall_mem}, {15'd0, e_smem});
            check("stall_if", {15'd0, stall_if}, {15'd0, e_sif});
        end
        rd_now = (mem_en === 1'b1) && (mem_wr === 1'b0);
        last_done_i = e_di; last_done_d = e_dd; last_wr = e_ack;
        n_kind = m_kind; n_age = m_age;
        if (rst) begin
            n_kind = 0; n_age = 0;
        end else if (m_kind == 0) begin
            if (dcache_miss) begin
                n_kind = 2; n_age = 0; m_base = dcache_miss_addr & 16'hFFF0; m_tgt_d = 1'b1;
            end else if (dwrite_req) begin
                n_kind = 1;
            end else if (icache_miss) begin
                n_kind = 2; n_age = 0; m_base = icache_miss_addr & 16'hFFF0; m_tgt_d = 1'b0;
            end
        end else if (m_kind == 1) begin
            n_kind = 0;
        end else begin
            if (m_age == 12) n_kind = 0;
            else n_age = m_age + 1;
        end
        @(posedge clk);
        #1;
        m_kind = n_kind; m_age = n_age;
        rd_pipe = {rd_pipe[2:0], rd_now};
        mem_data_valid = rd_pipe[3];
    endtask

    // Run until every request has been serviced; drop each as it completes.
    task automatic serve(input int budget);
        int n = 0;
        while ((dcache_miss || dwrite_req || icache_miss || m_kind != 0) && n < budget) begin
            cycle();
            n++;
            if (last_done_d) dcache_miss = 1'b0;
            if (last_done_i) icache_miss = 1'b0;
            if (last_wr)     dwrite_req  = 1'b0;
        end
        check("serve_budget", {15'd0, (dcache_miss || dwrite_req || icache_miss || m_kind != 0)}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; icache_miss = 1'b0; dcache_miss = 1'b0; dwrite_req = 1'b0;
        icache_miss_addr = 16'h0000; dcache_miss_addr = 16'h0000;
        dwrite_addr = 16'h0000; dwrite_data = 16'h0000; mem_data_valid = 1'b0;

        // Reset: every output zero once the state register is initialised.
        cycle();
        chk_en = 1'b1; chk_all = 1'b1;
        cycle();
        chk_all = 1'b0;
        rst = 1'b0;
        cycle();

        // D-miss alone at 0x1236.
        dcache_miss = 1'b1; dcache_miss_addr = 16'h1236;
        serve(40);
        cycle();

        // Simultaneous D-miss, write-through and I-miss.
        dcache_miss = 1'b1; dcache_miss_addr = 16'h2000;
        icache_miss = 1'b1; icache_miss_addr = 16'h0040;
        dwrite_req = 1'b1; dwrite_addr = 16'(($urandom & 32'hFFFE)); dwrite_data = 16'($urandom);
        serve(80);
        cycle();

        // Write-through alone.
        dwrite_req = 1'b1; dwrite_addr = 16'h0100; dwrite_data = 16'hBEEF;
        serve(10);
        cycle();

        // Non-preemption: D-miss arrives during an I-fill.
        icache_miss = 1'b1; icache_miss_addr = 16'($urandom);
        repeat (3) cycle();
        dcache_miss = 1'b1; dcache_miss_addr = 16'($urandom);
        serve(60);
        cycle();

        // Reset mid-fill at cycle 6, stale words drain, then restart from word 0.
        dcache_miss = 1'b1; dcache_miss_addr = 16'($urandom);
        repeat (6) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; dcache_miss = 1'b0;
        repeat (8) cycle();
        dcache_miss = 1'b1;
        serve(40);
        cycle();

        // Wrapping block at the top of memory, then a spurious valid in IDLE.
        icache_miss = 1'b1; icache_miss_addr = 16'hFFFA;
        serve(40);
        cycle();
        mem_data_valid = 1'b1;
        cycle();
        cycle();

        // Randomized request mixes.
        for (int i = 0; i < 20; i++) begin
            dcache_miss = 1'($urandom_range(0, 1));
            dcache_miss_addr = 16'($urandom);
            icache_miss = 1'($urandom_range(0, 1));
            icache_miss_addr = 16'($urandom);
            dwrite_req = 1'($urandom_range(0, 1));
            dwrite_addr = 16'($urandom);
            dwrite_data = 16'($urandom);
            serve(120);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
